// File: rtl/fake_mem_credit_bridge.sv
// Credit-to-val/rdy bridge for fake memory endpoints: ingress credit FIFO, egress
// delay FIFO with per-entry timestamps, downstream credit counter, flit counters, sticky errors.
module fake_mem_credit_bridge #(
    parameter int DATA_W      = 64,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_DEPTH   = 4,
    parameter int OUT_CREDITS = 4,
    parameter int DELAY_W     = 8,
    parameter int TS_W        = 10
) (
    input  logic               core_ref_clk,
    input  logic               sys_rst_n,
    input  logic [DATA_W-1:0]  noc_in_data,
    input  logic               noc_in_valid,
    output logic               noc_in_yummy,
    output logic [DATA_W-1:0]  mem_req_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    input  logic [DATA_W-1:0]  mem_resp_data,
    input  logic               mem_resp_valid,
    output logic               mem_resp_ready,
    output logic [DATA_W-1:0]  noc_out_data,
    output logic               noc_out_valid,
    input  logic               noc_out_yummy,
    input  logic [DELAY_W-1:0] cfg_resp_delay,
    output logic [63:0]        flit_i_cnt,
    output logic [63:0]        flit_o_cnt,
    output logic               err_overflow,
    output logic               err_credit
);

    localparam int IN_PW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
    localparam int CR_W   = $clog2(OUT_CREDITS + 1);

    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [IN_CW-1:0]  IN_ONE   = IN_CW'(1);
    localparam logic [IN_PW-1:0]  IN_LAST  = IN_PW'(IN_DEPTH - 1);
    localparam logic [IN_PW-1:0]  IN_PONE  = IN_PW'(1);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_ONE  = OUT_CW'(1);
    localparam logic [OUT_PW-1:0] OUT_LAST = OUT_PW'(OUT_DEPTH - 1);
    localparam logic [OUT_PW-1:0] OUT_PONE = OUT_PW'(1);
    localparam logic [CR_W-1:0]   CR_MAX   = CR_W'(OUT_CREDITS);
    localparam logic [CR_W-1:0]   CR_ONE   = CR_W'(1);
    localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);

    // ---------------- ingress ----------------
    logic [DATA_W-1:0] r_in_mem [IN_DEPTH];
    logic [IN_PW-1:0]  r_in_wr_ptr;
    logic [IN_PW-1:0]  r_in_rd_ptr;
    logic [IN_CW-1:0]  r_in_cnt;
    logic              r_in_yummy;
    logic [63:0]       r_flit_i_cnt;
    logic              r_err_overflow;
    logic              w_in_full;
    logic              w_in_wr;
    logic              w_in_rd;

    // Full check uses pre-read occupancy, so a write into a full FIFO drops even if it drains this cycle.
    assign w_in_full     = (r_in_cnt == IN_FULL);
    assign w_in_wr       = noc_in_valid && !w_in_full;
    assign mem_req_valid = (r_in_cnt != '0);
    assign mem_req_data  = r_in_mem[r_in_rd_ptr];
    assign w_in_rd       = mem_req_valid && mem_req_ready;
    assign noc_in_yummy  = r_in_yummy;
    assign flit_i_cnt    = r_flit_i_cnt;
    assign err_overflow  = r_err_overflow;

    always_ff @(posedge core_ref_clk) begin
        if (!sys_rst_n) begin
            r_in_wr_ptr    <= '0;
            r_in_rd_ptr    <= '0;
            r_in_cnt       <= '0;
            r_in_yummy     <= 1'b0;
            r_flit_i_cnt   <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_in_yummy <= w_in_rd;
            if (w_in_wr) begin
                r_in_mem[r_in_wr_ptr] <= noc_in_data;
                r_in_wr_ptr           <= (r_in_wr_ptr == IN_LAST) ? '0 : r_in_wr_ptr + IN_PONE;
                r_flit_i_cnt          <= r_flit_i_cnt + 64'd1;
            end
            if (noc_in_valid && w_in_full) begin
                r_err_overflow <= 1'b1;
            end
            if (w_in_rd) begin
                r_in_rd_ptr <= (r_in_rd_ptr == IN_LAST) ? '0 : r_in_rd_ptr + IN_PONE;
            end
            if (w_in_wr && !w_in_rd) begin
                r_in_cnt <= r_in_cnt + IN_ONE;
            end else if (!w_in_wr && w_in_rd) begin
                r_in_cnt <= r_in_cnt - IN_ONE;
            end
        end
    end

    // ---------------- egress ----------------
    logic [DATA_W-1:0] r_out_mem [OUT_DEPTH];
    logic [TS_W-1:0]   r_out_ts  [OUT_DEPTH];
    logic [OUT_PW-1:0] r_out_wr_ptr;
    logic [OUT_PW-1:0] r_out_rd_ptr;
    logic [OUT_CW-1:0] r_out_cnt;
    logic [TS_W-1:0]   r_now;
    logic [CR_W-1:0]   r_credits;
    logic [63:0]       r_flit_o_cnt;
    logic              r_err_credit;
    logic              w_out_empty;
    logic              w_out_wr;
    logic [TS_W-1:0]   w_head_age;
    logic              w_head_elig;
    logic              w_send;

    // Age is taken modulo 2^TS_W, so entries queued across a timestamp wrap still release on time.
    assign w_out_empty    = (r_out_cnt == '0);
    assign mem_resp_ready = (r_out_cnt != OUT_FULL);
    assign w_out_wr       = mem_resp_valid && mem_resp_ready;
    assign w_head_age     = r_now - r_out_ts[r_out_rd_ptr];
    assign w_head_elig    = !w_out_empty &&
                            (w_head_age >= {{(TS_W-DELAY_W){1'b0}}, cfg_resp_delay});
    assign w_send         = w_head_elig && (r_credits != '0);
    assign noc_out_valid  = w_send;
    assign noc_out_data   = w_out_empty ? '0 : r_out_mem[r_out_rd_ptr];
    assign flit_o_cnt     = r_flit_o_cnt;
    assign err_credit     = r_err_credit;

    always_ff @(posedge core_ref_clk) begin
        if (!sys_rst_n) begin
            r_out_wr_ptr <= '0;
            r_out_rd_ptr <= '0;
            r_out_cnt    <= '0;
            r_now        <= '0;
            r_credits    <= CR_MAX;
            r_flit_o_cnt <= '0;
            r_err_credit <= 1'b0;
        end else begin
            r_now <= r_now + TS_ONE;
            if (w_out_wr) begin
                r_out_mem[r_out_wr_ptr] <= mem_resp_data;
                r_out_ts[r_out_wr_ptr]  <= r_now;
                r_out_wr_ptr            <= (r_out_wr_ptr == OUT_LAST) ? '0 : r_out_wr_ptr + OUT_PONE;
            end
            if (w_send) begin
                r_out_rd_ptr <= (r_out_rd_ptr == OUT_LAST) ? '0 : r_out_rd_ptr + OUT_PONE;
                r_flit_o_cnt <= r_flit_o_cnt + 64'd1;
            end
            if (w_out_wr && !w_send) begin
                r_out_cnt <= r_out_cnt + OUT_ONE;
            end else if (!w_out_wr && w_send) begin
                r_out_cnt <= r_out_cnt - OUT_ONE;
            end
            // A yummy paired with a send cancels out and is never an overflow.
            case ({w_send, noc_out_yummy})
                2'b10:   r_credits <= r_credits - CR_ONE;
                2'b01: begin
                    if (r_credits == CR_MAX) begin
                        r_err_credit <= 1'b1;
                    end else begin
                        r_credits <= r_credits + CR_ONE;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule

// File: doc/fake_mem_credit_bridge.md
Name: fake_mem_credit_bridge

Overview:
Parametrised credit-to-memory-model bridge for chipset-side fake memory endpoints. It replaces the fixed credit_to_valrdy/valrdy_to_credit pair with a single block that has configurable ingress buffer depth, egress credit count and data width. It adds a runtime-programmable response-latency injector, flit counters and sticky protocol-error flags. It sits between the NoC2/NoC3 credit channels and a val/rdy memory model such as fake_mem_ctrl.

Parameters:
DATA_W, 64, flit width on all data ports
IN_DEPTH, 4, ingress FIFO entries; equals the credits the upstream sender holds
OUT_DEPTH, 4, egress (delay) FIFO entries
OUT_CREDITS, 4, initial and maximum downstream credits
DELAY_W, 8, width of cfg_resp_delay
TS_W, 10, timestamp width; must be at least DELAY_W+2

Ports:
core_ref_clk  in  1  clock
sys_rst_n  in  1  synchronous active-low reset
noc_in_data  in  DATA_W  NoC2 flit from processor
noc_in_valid  in  1  one-cycle pulse per flit
noc_in_yummy  out  1  credit return to processor
mem_req_data  out  DATA_W  flit to memory model
mem_req_valid  out  1  val/rdy valid
mem_req_ready  in  1  val/rdy ready
mem_resp_data  in  DATA_W  flit from memory model
mem_resp_valid  in  1  val/rdy valid
mem_resp_ready  out  1  val/rdy ready
noc_out_data  out  DATA_W  NoC3 flit to processor
noc_out_valid  out  1  one-cycle pulse per flit
noc_out_yummy  in  1  credit return from processor
cfg_resp_delay  in  DELAY_W  minimum response residency in cycles, sampled per entry at release check
flit_i_cnt  out  64  ingress flits accepted
flit_o_cnt  out  64  egress flits sent
err_overflow  out  1  sticky: noc_in_valid while ingress full
err_credit  out  1  sticky: noc_out_yummy while credits == OUT_CREDITS

Behaviour:
- Reset is synchronous on core_ref_clk with sys_rst_n=0. It empties both FIFOs, sets the credit counter to OUT_CREDITS, and clears the timestamp counter, both flit counters and both error flags.
- Outputs during and immediately after reset: noc_in_yummy=0, mem_req_valid=0, mem_resp_ready=1, noc_out_valid=0.
- Reset asserted mid-operation discards all buffered flits and does not return credits in either direction.
- Ingress path:
  - noc_in_valid=1 with the FIFO not full writes the flit and increments flit_i_cnt.
  - noc_in_valid=1 with the FIFO full drops the flit, sets err_overflow and leaves the counter unchanged.
  - mem_req_valid = FIFO not empty; mem_req_data = FIFO head. Both are driven from registered state only.
  - A flit written in cycle t is visible on mem_req in cycle t+1. There is no bypass.
  - Simultaneous write and read while full is not allowed: the full check uses pre-read occupancy.
  - noc_in_yummy is a registered one-cycle pulse in cycle t+1 for each dequeue (mem_req_valid and mem_req_ready) in cycle t. Back-to-back dequeues give back-to-back pulses.
- Egress path:
  - mem_resp_ready = egress FIFO not full.
  - On each accept, the entry stores the data plus ts = now. now is a free-running TS_W-bit counter that wraps modulo 2^TS_W.
  - The head is eligible when (now - ts) mod 2^TS_W >= cfg_resp_delay.
  - A response accepted in cycle t is therefore first eligible in cycle t+max(1, cfg_resp_delay).
  - FIFO order is preserved: a younger entry never overtakes the head.
  - noc_out_valid = head eligible AND credits > 0. It is combinational from registered state.
  - noc_out_data = head data whenever the FIFO is non-empty, else 0.
  - Each cycle with noc_out_valid=1 pops the head, decrements credits and increments flit_o_cnt. The downstream has no backpressure other than credits.
- Credit counter:
  - yummy only: +1. If credits == OUT_CREDITS, they stay at OUT_CREDITS and err_credit is set.
  - send only: -1.
  - send and yummy in the same cycle: unchanged, with no error even at maximum.
  - credits == 0 blocks sending. The yummy arriving in cycle t enables a send in cycle t+1.
- cfg_resp_delay changes take effect on the next eligibility evaluation. They apply to entries already queued.
- Counters wrap modulo 2^64 silently. Error flags clear only on reset.

Test Plan:
- Reset then idle 10 cycles -> credits=4, mem_resp_ready=1, all valids/yummy/counters/errors 0.
- 4 back-to-back noc_in flits 0xA0..0xA3 with mem_req_ready=0, then a 5th -> err_overflow=1, flit_i_cnt=4. Then raise ready -> mem_req_data 0xA0..0xA3 in order and exactly 4 yummy pulses, each one cycle after its dequeue.
- cfg_resp_delay=0, response 0x55 accepted in cycle t -> noc_out_valid in cycle t+1. With cfg_resp_delay=20 -> noc_out_valid in cycle t+20 exactly.
- 6 responses with no yummy returned -> exactly 4 sends, the remainder held. One yummy in cycle t -> 5th send in cycle t+1. Simultaneous send and yummy -> credits unchanged.
- Extra yummy with credits=4 -> err_credit=1, credits remain 4.
- Run until the now counter wraps with an entry queued across the wrap (ts=1020, delay=10) -> released at now=6. Reset asserted while both FIFOs are non-empty -> all flushed and no yummy emitted.
